// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit sequencer for the E stage of a 5-stage MIPS pipeline.
// It owns the HI/LO registers and computes results when an op starts. It holds
// those results for a fixed busy latency and then commits them to HI/LO.
// md_stall holds a D-stage mul/div-class instruction while the unit is busy or starting.
//
// Ports:
//   clk      in   1   system clock, rising-edge active
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   E-stage instruction is a valid MDU op this cycle
//   op       in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 reserved)
//   rs_val   in  32   forwarded rs operand
//   rt_val   in  32   forwarded rt operand
//   d_is_md  in   1   D-stage instruction is a mul/div/move-HI/LO class op
//   busy     out  1   arithmetic op in progress (registered)
//   md_stall out  1   stall request to the hazard unit
//   hi       out 32   HI register
//   lo       out 32   LO register
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]  state_r;
    logic [3:0]  count_r;
    logic        div0_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        is_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Result datapath: product and sign-corrected quotient/remainder for the current operands.
    always_comb begin
        // MULT and DIV (even op codes) are the signed variants.
        is_signed_s = ~op[0];
        // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
        // correct for both signed and unsigned operands.
        mul_a_s     = {{32{is_signed_s & rs_val[31]}}, rs_val};
        mul_b_s     = {{32{is_signed_s & rt_val[31]}}, rt_val};
        product_s   = mul_a_s * mul_b_s;
        // Divide on magnitudes and then restore the signs. This truncates toward zero,
        // and 0x80000000 / -1 naturally yields 0x80000000 with remainder 0.
        a_neg_s     = is_signed_s & rs_val[31];
        b_neg_s     = is_signed_s & rt_val[31];
        a_mag_s     = a_neg_s ? (~rs_val + 32'd1) : rs_val;
        // A zero divisor is replaced by 1 to keep the divider defined; the commit is suppressed anyway.
        b_mag_s     = (rt_val == 32'd0) ? 32'd1 : (b_neg_s ? (~rt_val + 32'd1) : rt_val);
        q_mag_s     = a_mag_s / b_mag_s;
        r_mag_s     = a_mag_s % b_mag_s;
        quot_s      = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
        rem_s       = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;
    end

    // Sequencer: start, busy countdown, commit and HI/LO moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= 4'd0;
            div0_r    <= 1'b0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_r <= product_s[63:32];
                                pend_lo_r <= product_s[31:0];
                                div0_r    <= 1'b0;
                                count_r   <= 4'(MULT_CYCLES);
                                state_r   <= ST_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_r <= rem_s;
                                pend_lo_r <= quot_s;
                                div0_r    <= (rt_val == 32'd0);
                                count_r   <= 4'(DIV_CYCLES);
                                state_r   <= ST_BUSY;
                            end
                            OP_MTHI: hi_r <= rs_val;
                            OP_MTLO: lo_r <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Any start arriving while busy is deliberately ignored.
                    count_r <= count_r - 4'd1;
                    if (count_r == 4'd1) begin
                        if (!div0_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                        div0_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 4'd0;
                end
            endcase
        end
    end

    assign busy     = (state_r == ST_BUSY);
    // The stall covers the start cycle too, so a following mul/div op cannot slip in.
    assign md_stall = d_is_md & (busy | (start & (op <= OP_DIVU)));
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model of HI/LO and latency.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        d_is_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic int exp_cycles(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1) return 5;
        if (o == 3'd2 || o == 3'd3) return 10;
        return 0;
    endfunction

    // Architectural effect of one op on HI/LO, written with plain arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            3'd2: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; exp_lo = sq[31:0]; exp_hi = sr[31:0]; end
            3'd3: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Drive one op for one cycle, then count busy cycles (bounded) and tally stall misbehaviour.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic dm, output int ncyc, output int stall_err,
                         output logic stall_at_start);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; d_is_md = dm;
        #1 stall_at_start = md_stall;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        ncyc = 0; stall_err = 0;
        #1;
        while (busy === 1'b1 && ncyc < 40) begin
            if (md_stall !== dm) stall_err++;
            ncyc++;
            @(negedge clk);
            #1;
        end
        if (md_stall !== 1'b0) stall_err++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", md_stall); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'd0) begin errors++; $display("FAIL post_reset: busy %b hi %h expected 0/0", busy, hi); end
    endtask

    task automatic test_mult();
        int n, se; logic sst;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, n, se, sst);
        model_apply(3'd0, 32'hFFFF_FFFF, 32'd2);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_result: got %h/%h expected ffffffff/fffffffe", hi, lo); end
    endtask

    task automatic test_multu();
        int n, se; logic sst;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, n, se, sst);
        model_apply(3'd1, 32'hFFFF_FFFF, 32'd2);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
        checks++; if (sst !== 1'b1) begin errors++; $display("FAIL multu_start_stall: got %b expected 1", sst); end
        checks++; if (se != 0) begin errors++; $display("FAIL multu_stall: %0d bad cycles expected 0", se); end
        checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result: got %h/%h expected 00000001/fffffffe", hi, lo); end
    endtask

    task automatic test_div();
        int n, se; logic sst;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, n, se, sst);
        model_apply(3'd2, 32'hFFFF_FFF9, 32'd2);
        checks++; if (n != 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h/%h expected ffffffff/fffffffd", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        int n, se; logic sst;
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, n, se, sst);
        model_apply(3'd4, 32'hDEAD_BEEF, 32'd0);
        checks++; if (n != 0) begin errors++; $display("FAIL mthi_busy: got %0d busy cycles expected 0", n); end
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_value: got %h expected deadbeef", hi); end
        issue(3'd5, 32'h0000_1234, 32'd0, 1'b0, n, se, sst);
        model_apply(3'd5, 32'h0000_1234, 32'd0);
        checks++; if (lo !== 32'h0000_1234 || hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_value: got %h/%h expected deadbeef/00001234", hi, lo); end
    endtask

    task automatic test_divu_zero();
        int n, se; logic sst;
        issue(3'd4, 32'h11, 32'd0, 1'b0, n, se, sst);
        issue(3'd5, 32'h22, 32'd0, 1'b0, n, se, sst);
        model_apply(3'd4, 32'h11, 32'd0);
        model_apply(3'd5, 32'h22, 32'd0);
        issue(3'd3, 32'd7, 32'd0, 1'b0, n, se, sst);
        model_apply(3'd3, 32'd7, 32'd0);
        checks++; if (n != 10) begin errors++; $display("FAIL div0_cycles: got %0d expected 10", n); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL div0_hold: got %h/%h expected 00000011/00000022", hi, lo); end
    endtask

    task automatic test_ignore();
        int n = 0;
        int se = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'hFFFF_FFFB; d_is_md = 1'b0;
        #1 if (md_stall !== 1'b0) se++;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            if (n == 2) begin
                start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            #1 if (md_stall !== 1'b0) se++;
            n++;
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;
        model_apply(3'd0, 32'd3, 32'hFFFF_FFFB);
        checks++; if (n != 5) begin errors++; $display("FAIL ignore_cycles: got %0d expected 5", n); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL ignore_result: got %h/%h expected ffffffff/fffffff1", hi, lo); end
        checks++; if (se != 0) begin errors++; $display("FAIL ignore_stall: %0d bad cycles expected 0", se); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: busy %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; d_is_md = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_inflight: busy %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL arst_busy: busy %b stall %b expected 0/0", busy, md_stall); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL arst_hilo: got %h/%h expected 0/0", hi, lo); end
        #3 rst_n = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (12) @(negedge clk);
        d_is_md = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL arst_no_commit: busy %b hi %h lo %h expected 0/0/0", busy, hi, lo); end
    endtask

    task automatic test_random();
        int n, se; logic sst;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic        dm;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            dm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(o, a, b, dm, n, se, sst);
            model_apply(o, a, b);
            checks++; if (n != exp_cycles(o)) begin errors++; $display("FAIL rand_cycles[%0d] op%0d: got %0d expected %0d", i, o, n, exp_cycles(o)); end
            checks++; if (hi !== exp_hi) begin errors++; $display("FAIL rand_hi[%0d] op%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, exp_hi); end
            checks++; if (lo !== exp_lo) begin errors++; $display("FAIL rand_lo[%0d] op%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, exp_lo); end
            checks++; if (sst !== (dm & (o <= 3'd3))) begin errors++; $display("FAIL rand_start_stall[%0d]: got %b expected %b", i, sst, dm & (o <= 3'd3)); end
            checks++; if (se != 0) begin errors++; $display("FAIL rand_stall[%0d]: %0d bad cycles expected 0", i, se); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_mthi_mtlo();
        test_ignore();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
